vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 116 +++++++++++
 tb/tb_vga_sync_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable divider, h/v raster counters,
// registered active-low syncs, blanked colour and a frame-start pulse.
// Sync and colour share one pixel of latency relative to x/y.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Inclusive range test used for both sync windows.
  function automatic logic in_window(input logic [9:0] val,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  logic       tick_p0;
  logic [9:0] h_count_p0;
  logic [9:0] v_count_p0;
  logic       h_last_p0;
  logic       v_last_p0;
  logic       video_on_p0;

  logic       hsync_p1;
  logic       vsync_p1;
  logic [2:0] rgb_p1;
  logic       frame_start_p1;

  // ---- stage p0: pixel enable and raster position ----

  // Divide-by-two pixel enable; first high right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_p0 <= 1'b0;
    else        tick_p0 <= ~tick_p0;
  end

  assign h_last_p0 = (h_count_p0 == H_MAX);
  assign v_last_p0 = (v_count_p0 == V_MAX);

  // Raster counters advance once per pixel and wrap at the line/frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_p0 <= '0;
      v_count_p0 <= '0;
    end else if (tick_p0) begin
      if (h_last_p0) begin
        h_count_p0 <= '0;
        v_count_p0 <= v_last_p0 ? 10'd0 : v_count_p0 + 10'd1;
      end else begin
        h_count_p0 <= h_count_p0 + 10'd1;
      end
    end
  end

  assign video_on_p0 = (h_count_p0 < H_VIS) && (v_count_p0 < V_VIS);

  // ---- stage p1: registered syncs and colour, one pixel behind x/y ----

  // Syncs and blanked colour are captured from the current pixel on each enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      rgb_p1   <= 3'b000;
    end else if (tick_p0) begin
      hsync_p1 <= ~in_window(h_count_p0, HS_FIRST, HS_LAST);
      vsync_p1 <= ~in_window(v_count_p0, VS_FIRST, VS_LAST);
      rgb_p1   <= video_on_p0 ? rgb_in : 3'b000;
    end
  end

  // Single-clk pulse on the edge where the raster wraps back to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_start_p1 <= 1'b0;
    else        frame_start_p1 <= tick_p0 && h_last_p0 && v_last_p0;
  end

  assign x           = h_count_p0;
  assign y           = v_count_p0;
  assign video_on    = video_on_p0;
  assign p_tick      = tick_p0;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign rgb_out     = rgb_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a scaled-down raster so that whole
// frames fit in a short run; all timing expectations derive from the
// bench's own parameters.
module tb_vga_sync_gen;

  localparam int HD = 10, HF = 3, HS = 4, HB = 3;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;          // 20 pixels per line
  localparam int VT = VD + VF + VS + VB;          // 13 lines per frame
  localparam int LINE_CLK  = 2 * HT;              // 40 clk
  localparam int FRAME_CLK = 2 * HT * VT;         // 520 clk
  localparam int HS_START  = HD + HF;             // 13
  localparam int VS_START  = VD + VF;             // 8

  logic       clk;
  logic       rst_n;
  logic [2:0] rgb_in;
  logic [9:0] x, y;
  logic       video_on, p_tick, hsync, vsync, frame_start;
  logic [2:0] rgb_out;

  int checks   = 0;
  int failures = 0;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .x(x), .y(y), .video_on(video_on), .p_tick(p_tick),
    .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic wait_xy(input int xv, input int yv, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRAME_CLK + 20; i++) begin
      @(negedge clk);
      if (int'(x) == xv && int'(y) == yv) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    rgb_in = 3'b000;
    repeat (2) @(negedge clk);
    checks++; if (x !== 10'd0)       begin failures++; $display("FAIL reset_x got=%0d exp=0", x); end
    checks++; if (y !== 10'd0)       begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (video_on !== 1'b1) begin failures++; $display("FAIL reset_video_on got=%b exp=1", video_on); end
    checks++; if (p_tick !== 1'b0)   begin failures++; $display("FAIL reset_p_tick got=%b exp=0", p_tick); end
    checks++; if (hsync !== 1'b1)    begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1)    begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    checks++; if (rgb_out !== 3'b000) begin failures++; $display("FAIL reset_rgb got=%b exp=000", rgb_out); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
  endtask

  task automatic test_startup();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (p_tick !== 1'b1 || x !== 10'd0) begin failures++; $display("FAIL start_e1 got p_tick=%b x=%0d exp p_tick=1 x=0", p_tick, x); end
    @(negedge clk);
    checks++; if (p_tick !== 1'b0 || x !== 10'd1) begin failures++; $display("FAIL start_e2 got p_tick=%b x=%0d exp p_tick=0 x=1", p_tick, x); end
    @(negedge clk);
    checks++; if (p_tick !== 1'b1 || x !== 10'd1) begin failures++; $display("FAIL start_e3 got p_tick=%b x=%0d exp p_tick=1 x=1", p_tick, x); end
    @(negedge clk);
    checks++; if (x !== 10'd2 || y !== 10'd0 || hsync !== 1'b1) begin failures++; $display("FAIL start_e4 got x=%0d y=%0d hsync=%b exp x=2 y=0 hsync=1", x, y, hsync); end
  endtask

  task automatic test_two_frames();
    logic [9:0] lx, ly;
    logic lhs, lvs, lfs, lpt, prev_vis;
    logic [2:0] exp_rgb;
    bit found;
    int last_fs, last_line, hs_t0, vs_t0;
    int fs_count, fs_wide, wrap_bad, lines, line_bad;
    int hs_falls, hs_bad, hs_len_bad, vs_falls, hs_in_vs;
    int range_bad, von_bad, rgb_bad, rgb_on, pt_bad;
    rgb_in = 3'b101;
    lx = x; ly = y;
    found = 1'b0;
    for (int g = 0; g < FRAME_CLK + 20 && !found; g++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
      else begin lx = x; ly = y; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL fs_first got=timeout exp=pulse within %0d clk", FRAME_CLK + 20); return; end
    checks++; if (int'(lx) != HT - 1 || int'(ly) != VT - 1) begin failures++; $display("FAIL wrap_before got=(%0d,%0d) exp=(%0d,%0d)", lx, ly, HT - 1, VT - 1); end
    checks++; if (x !== 10'd0 || y !== 10'd0) begin failures++; $display("FAIL wrap_after got=(%0d,%0d) exp=(0,0)", x, y); end

    lx = x; ly = y; lhs = hsync; lvs = vsync; lfs = frame_start; lpt = p_tick;
    prev_vis = 1'b0;
    last_fs = 0; last_line = 0; hs_t0 = 0; vs_t0 = 0;
    fs_count = 0; fs_wide = 0; wrap_bad = 0; lines = 0; line_bad = 0;
    hs_falls = 0; hs_bad = 0; hs_len_bad = 0; vs_falls = 0; hs_in_vs = 0;
    range_bad = 0; von_bad = 0; rgb_bad = 0; rgb_on = 0; pt_bad = 0;

    for (int n = 1; n <= 2 * FRAME_CLK; n++) begin
      @(negedge clk);
      if (x !== lx || y !== ly) prev_vis = (int'(lx) < HD) && (int'(ly) < VD);
      exp_rgb = prev_vis ? 3'b101 : 3'b000;
      if (rgb_out !== exp_rgb) rgb_bad++;
      if (rgb_out === 3'b101) rgb_on++;
      if (int'(x) >= HT || int'(y) >= VT) range_bad++;
      if (video_on !== ((int'(x) < HD) && (int'(y) < VD))) von_bad++;
      if (p_tick === lpt) pt_bad++;
      if (frame_start === 1'b1) begin
        fs_count++;
        if (lfs === 1'b1) fs_wide++;
        if (int'(lx) != HT - 1 || int'(ly) != VT - 1 || x !== 10'd0 || y !== 10'd0) wrap_bad++;
        checks++; if (n - last_fs != FRAME_CLK) begin failures++; $display("FAIL fs_period got=%0d exp=%0d", n - last_fs, FRAME_CLK); end
        last_fs = n;
      end
      if (x === 10'd0 && int'(lx) == HT - 1) begin
        lines++;
        if (n - last_line != LINE_CLK) line_bad++;
        last_line = n;
      end
      if (hsync === 1'b0 && lhs === 1'b1) begin
        hs_falls++;
        if (int'(x) != HS_START + 1) hs_bad++;
        if (vsync === 1'b0) hs_in_vs++;
        hs_t0 = n;
      end
      if (hsync === 1'b1 && lhs === 1'b0 && n - hs_t0 != 2 * HS) hs_len_bad++;
      if (vsync === 1'b0 && lvs === 1'b1) begin
        vs_falls++;
        vs_t0 = n;
        checks++; if (int'(y) != VS_START || x !== 10'd1) begin failures++; $display("FAIL vs_fall_pos got=(%0d,%0d) exp=(1,%0d)", x, y, VS_START); end
      end
      if (vsync === 1'b1 && lvs === 1'b0) begin
        checks++; if (n - vs_t0 != LINE_CLK * VS) begin failures++; $display("FAIL vs_len got=%0d exp=%0d", n - vs_t0, LINE_CLK * VS); end
      end
      lx = x; ly = y; lhs = hsync; lvs = vsync; lfs = frame_start; lpt = p_tick;
      // Second frame: garbage colour on cycles that must not be sampled.
      rgb_in = (n < FRAME_CLK || p_tick) ? 3'b101 : 3'b010;
    end
    rgb_in = 3'b101;

    checks++; if (fs_count != 2)       begin failures++; $display("FAIL fs_count got=%0d exp=2", fs_count); end
    checks++; if (fs_wide != 0)        begin failures++; $display("FAIL fs_width got=%0d wide pulses exp=0", fs_wide); end
    checks++; if (wrap_bad != 0)       begin failures++; $display("FAIL fs_wrap got=%0d bad exp=0", wrap_bad); end
    checks++; if (lines != 2 * VT)     begin failures++; $display("FAIL line_count got=%0d exp=%0d", lines, 2 * VT); end
    checks++; if (line_bad != 0)       begin failures++; $display("FAIL line_len got=%0d bad exp=0", line_bad); end
    checks++; if (hs_falls != 2 * VT)  begin failures++; $display("FAIL hs_count got=%0d exp=%0d", hs_falls, 2 * VT); end
    checks++; if (hs_bad != 0)         begin failures++; $display("FAIL hs_start_pos got=%0d bad exp=0", hs_bad); end
    checks++; if (hs_len_bad != 0)     begin failures++; $display("FAIL hs_len got=%0d bad exp=0", hs_len_bad); end
    checks++; if (vs_falls != 2)       begin failures++; $display("FAIL vs_count got=%0d exp=2", vs_falls); end
    checks++; if (hs_in_vs != 2 * VS)  begin failures++; $display("FAIL hs_during_vs got=%0d exp=%0d", hs_in_vs, 2 * VS); end
    checks++; if (range_bad != 0)      begin failures++; $display("FAIL count_range got=%0d bad exp=0", range_bad); end
    checks++; if (von_bad != 0)        begin failures++; $display("FAIL video_on got=%0d bad exp=0", von_bad); end
    checks++; if (rgb_bad != 0)        begin failures++; $display("FAIL rgb_blank got=%0d bad exp=0", rgb_bad); end
    checks++; if (rgb_on != 4 * HD * VD) begin failures++; $display("FAIL rgb_on_clk got=%0d exp=%0d", rgb_on, 4 * HD * VD); end
    checks++; if (pt_bad != 0)         begin failures++; $display("FAIL p_tick_toggle got=%0d bad exp=0", pt_bad); end
  endtask

  task automatic test_rgb_pattern();
    bit ok;
    rgb_in = 3'b011;
    wait_xy(3, 0, ok);
    checks++; if (!ok || rgb_out !== 3'b011) begin failures++; $display("FAIL rgb_vis_011 got=%b ok=%0d exp=011", rgb_out, ok); end
    wait_xy(HD + 1, 0, ok);
    checks++; if (!ok || rgb_out !== 3'b000) begin failures++; $display("FAIL rgb_hblank got=%b ok=%0d exp=000", rgb_out, ok); end
    rgb_in = 3'b110;
    wait_xy(HD, VD - 1, ok);
    checks++; if (!ok || rgb_out !== 3'b110) begin failures++; $display("FAIL rgb_last_pixel got=%b ok=%0d exp=110", rgb_out, ok); end
    wait_xy(HD + 1, VD - 1, ok);
    checks++; if (!ok || rgb_out !== 3'b000) begin failures++; $display("FAIL rgb_after_last got=%b ok=%0d exp=000", rgb_out, ok); end
    wait_xy(3, VD, ok);
    checks++; if (!ok || rgb_out !== 3'b000) begin failures++; $display("FAIL rgb_vblank got=%b ok=%0d exp=000", rgb_out, ok); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_xy(HS_START + 1, VS_START + 1, ok);
    checks++; if (!ok || hsync !== 1'b0 || vsync !== 1'b0) begin failures++; $display("FAIL mid_pre got hsync=%b vsync=%b ok=%0d exp 0 0 1", hsync, vsync, ok); end
    #5 rst_n = 1'b0;
    #1;
    checks++; if (x !== 10'd0 || y !== 10'd0) begin failures++; $display("FAIL mid_rst_xy got=(%0d,%0d) exp=(0,0)", x, y); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("FAIL mid_rst_sync got hsync=%b vsync=%b exp 1 1", hsync, vsync); end
    checks++; if (video_on !== 1'b1 || p_tick !== 1'b0 || rgb_out !== 3'b000 || frame_start !== 1'b0) begin
      failures++; $display("FAIL mid_rst_misc got von=%b pt=%b rgb=%b fs=%b exp 1 0 000 0", video_on, p_tick, rgb_out, frame_start);
    end
    repeat (2) @(negedge clk);
    checks++; if (x !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("FAIL mid_rst_hold got x=%0d hs=%b vs=%b exp 0 1 1", x, hsync, vsync); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (x !== 10'd1 || y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
      failures++; $display("FAIL mid_restart got x=%0d y=%0d hs=%b vs=%b exp 1 0 1 1", x, y, hsync, vsync);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rgb_in = 3'b000;
    test_reset();
    test_startup();
    test_two_frames();
    test_rgb_pattern();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
